// File: rtl/pipeline_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: PC-select encodings,
// reset/exception vectors and the bubble encoding.
package pipeline_if_stage_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ   = 3'd0,
    PCSRC_BR    = 3'd1,
    PCSRC_J     = 3'd2,
    PCSRC_JR    = 3'd3,
    PCSRC_IRQ   = 3'd4,
    PCSRC_ILLOP = 3'd5
  } pcsrc_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h8000_0000;
  localparam logic [31:0] ILLOP_ADDR_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR_DEF  = 32'h8000_0008;
  localparam logic [31:0] NOP            = 32'h0000_0000;

  // Increment never touches the kernel bit; the low 31 bits wrap on their own.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pipeline_if_stage_if.sv
// Bundle of the IF stage's control, redirect and ROM signals.
// master = ID/hazard/ROM side that drives the stage, slave = the IF stage.
interface pipeline_if_stage_if;

  logic        IF_stall;
  logic [2:0]  ID_PCSrc;
  logic        IDcontrol_Branch;
  logic [31:0] ID_ConBA;
  logic [25:0] ID_JT;
  logic [31:0] ID_JrTarget;
  logic [31:0] IM_data;
  logic [31:0] IM_addr;
  logic [31:0] ID_PC;
  logic [31:0] ID_instruction;
  logic        IF_flush;

  modport master (
    output IF_stall, ID_PCSrc, IDcontrol_Branch, ID_ConBA, ID_JT, ID_JrTarget, IM_data,
    input  IM_addr, ID_PC, ID_instruction, IF_flush
  );

  modport slave (
    input  IF_stall, ID_PCSrc, IDcontrol_Branch, ID_ConBA, ID_JT, ID_JrTarget, IM_data,
    output IM_addr, ID_PC, ID_instruction, IF_flush
  );

endinterface

// File: rtl/pipeline_if_stage_pc_next_mux.sv
// Next-PC priority selection for the fetch stage. Purely combinational;
// also reports whether the current fetch is squashed or the stage must hold.
module pc_next_mux
  import pipeline_if_stage_pkg::*;
#(
  parameter logic [31:0] ILLOP_ADDR = ILLOP_ADDR_DEF,
  parameter logic [31:0] XADR_ADDR  = XADR_ADDR_DEF
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc_inc,
  input  logic [3:0]  id_pc_hi,
  input  logic        stall,
  input  logic [2:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] con_ba,
  input  logic [25:0] jt,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        flush,
  output logic        hold
);

  always_comb begin
    next_pc = pc_inc;
    flush   = 1'b0;
    hold    = 1'b0;
    // Exception vectors preempt a stall; branch/jump resolution must wait for it.
    if (pcsrc == PCSRC_IRQ) begin
      next_pc = ILLOP_ADDR;
      flush   = 1'b1;
    end else if (pcsrc == PCSRC_ILLOP) begin
      next_pc = XADR_ADDR;
      flush   = 1'b1;
    end else if (stall) begin
      next_pc = pc;
      hold    = 1'b1;
    end else begin
      case (pcsrc)
        PCSRC_J: begin
          next_pc = {id_pc_hi, jt, 2'b00};
          flush   = 1'b1;
        end
        PCSRC_JR: begin
          // A user-mode jr cannot set the kernel bit.
          next_pc = {jr_target[31] & id_pc_hi[3], jr_target[30:0]};
          flush   = 1'b1;
        end
        PCSRC_BR: begin
          if (branch_taken) begin
            next_pc = con_ba;
            flush   = 1'b1;
          end
        end
        default: begin
          next_pc = pc_inc;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS core: owns the PC and the
// IF/ID pipeline register, applies ID redirects and hazard stalls.
module pipeline_if_stage
  import pipeline_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] ILLOP_ADDR = ILLOP_ADDR_DEF,
  parameter logic [31:0] XADR_ADDR  = XADR_ADDR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pipeline_if_stage_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] pc_inc;
  logic [31:0] next_pc;
  logic        flush;
  logic        hold;

  assign pc_inc = pc_plus4(pc_q);

  pc_next_mux #(
    .ILLOP_ADDR (ILLOP_ADDR),
    .XADR_ADDR  (XADR_ADDR)
  ) u_pc_next_mux (
    .pc           (pc_q),
    .pc_inc       (pc_inc),
    .id_pc_hi     (id_pc_q[31:28]),
    .stall        (bus.IF_stall),
    .pcsrc        (bus.ID_PCSrc),
    .branch_taken (bus.IDcontrol_Branch),
    .con_ba       (bus.ID_ConBA),
    .jt           (bus.ID_JT),
    .jr_target    (bus.ID_JrTarget),
    .next_pc      (next_pc),
    .flush        (flush),
    .hold         (hold)
  );

  always_comb begin
    pc_d       = next_pc;
    id_pc_d    = pc_inc;
    id_instr_d = bus.IM_data;
    // A squashed fetch still records its PC+4 so ID_PC tracks the bubble.
    if (flush) begin
      id_instr_d = NOP;
    end else if (hold) begin
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= RESET_PC;
      id_instr_q <= NOP;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign bus.IM_addr        = pc_q;
  assign bus.ID_PC          = id_pc_q;
  assign bus.ID_instruction = id_instr_q;
  assign bus.IF_flush       = flush & ~reset;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Directed bench for pipeline_if_stage: reset, branches, stalls, jumps,
// exception vectors and kernel/user PC wrap.
module tb_pipeline_if_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pipeline_if_stage_if bus ();

  pipeline_if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bus.IM_data = rom(bus.IM_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.IF_stall         = 1'b0;
    bus.ID_PCSrc         = 3'd0;
    bus.IDcontrol_Branch = 1'b0;
    bus.ID_ConBA         = 32'h0;
    bus.ID_JT            = 26'h0;
    bus.ID_JrTarget      = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ID_PCSrc = 3'd4;
    #12;
    chk("rst_addr", bus.IM_addr, 32'h8000_0000);
    chk("rst_idpc", bus.ID_PC, 32'h8000_0000);
    chk("rst_instr", bus.ID_instruction, 32'h0);
    chk("rst_flush", {31'h0, bus.IF_flush}, 32'h0);
    clear_ctrl();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("rel_addr1", bus.IM_addr, 32'h8000_0004);
    chk("rel_instr1", bus.ID_instruction, rom(32'h8000_0000));
    chk("rel_idpc1", bus.ID_PC, 32'h8000_0004);
    tick();
    chk("rel_addr2", bus.IM_addr, 32'h8000_0008);
    // Asynchronous reset mid-cycle takes effect without a clock edge.
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", bus.IM_addr, 32'h8000_0000);
    chk("mid_rst_instr", bus.ID_instruction, 32'h0);
    chk("mid_rst_idpc", bus.ID_PC, 32'h8000_0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("rerel_addr1", bus.IM_addr, 32'h8000_0004);
    tick();
    chk("rerel_addr2", bus.IM_addr, 32'h8000_0008);
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick();
    chk("br_pre_addr", bus.IM_addr, 32'h8000_000C);
    bus.ID_PCSrc = 3'd1;
    bus.IDcontrol_Branch = 1'b1;
    bus.ID_ConBA = 32'h8000_0040;
    #1;
    chk("br_flush", {31'h0, bus.IF_flush}, 32'h1);
    tick();
    chk("br_addr", bus.IM_addr, 32'h8000_0040);
    chk("br_bubble", bus.ID_instruction, 32'h0);
    chk("br_idpc", bus.ID_PC, 32'h8000_0010);
    clear_ctrl();
    tick();
    chk("br_post_addr", bus.IM_addr, 32'h8000_0044);
    chk("br_post_instr", bus.ID_instruction, rom(32'h8000_0040));
    chk("br_post_idpc", bus.ID_PC, 32'h8000_0044);
  endtask

  task automatic test_not_taken_stall();
    bus.ID_PCSrc = 3'd1;
    bus.IDcontrol_Branch = 1'b0;
    bus.ID_ConBA = 32'h8000_0400;
    #1;
    chk("nt_flush", {31'h0, bus.IF_flush}, 32'h0);
    tick();
    chk("nt_addr", bus.IM_addr, 32'h8000_0048);
    chk("nt_instr", bus.ID_instruction, rom(32'h8000_0044));
    clear_ctrl();
    // A pending jump must not resolve while stalled.
    bus.IF_stall = 1'b1;
    bus.ID_PCSrc = 3'd2;
    bus.ID_JT = 26'h3FF;
    #1;
    chk("st_flush", {31'h0, bus.IF_flush}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_addr", bus.IM_addr, 32'h8000_0048);
      chk("st_idpc", bus.ID_PC, 32'h8000_0048);
      chk("st_instr", bus.ID_instruction, rom(32'h8000_0044));
    end
    clear_ctrl();
    tick();
    chk("st_rel_addr", bus.IM_addr, 32'h8000_004C);
    chk("st_rel_instr", bus.ID_instruction, rom(32'h8000_0048));
  endtask

  task automatic test_jumps();
    do_reset();
    tick(); tick(); tick(); tick();
    chk("j_pre_idpc", bus.ID_PC, 32'h8000_0010);
    bus.ID_PCSrc = 3'd2;
    bus.ID_JT = 26'h10;
    #1;
    chk("j_flush", {31'h0, bus.IF_flush}, 32'h1);
    tick();
    chk("j_addr", bus.IM_addr, 32'h8000_0040);
    chk("j_bubble", bus.ID_instruction, 32'h0);
    chk("j_idpc", bus.ID_PC, 32'h8000_0014);
    clear_ctrl();
    bus.ID_PCSrc = 3'd1;
    bus.IDcontrol_Branch = 1'b1;
    bus.ID_ConBA = 32'h0000_001C;
    tick();
    chk("u_addr", bus.IM_addr, 32'h0000_001C);
    clear_ctrl();
    tick();
    chk("u_idpc", bus.ID_PC, 32'h0000_0020);
    bus.ID_PCSrc = 3'd3;
    bus.ID_JrTarget = 32'h8000_0100;
    #1;
    chk("jr_flush", {31'h0, bus.IF_flush}, 32'h1);
    tick();
    chk("jr_user_addr", bus.IM_addr, 32'h0000_0100);
    chk("jr_bubble", bus.ID_instruction, 32'h0);
    chk("jr_idpc", bus.ID_PC, 32'h0000_0024);
    clear_ctrl();
  endtask

  task automatic test_irq_stall();
    bus.IF_stall = 1'b1;
    bus.ID_PCSrc = 3'd4;
    #1;
    chk("irq_flush", {31'h0, bus.IF_flush}, 32'h1);
    tick();
    chk("irq_addr", bus.IM_addr, 32'h8000_0004);
    chk("irq_bubble", bus.ID_instruction, 32'h0);
    chk("irq_idpc", bus.ID_PC, 32'h0000_0104);
    clear_ctrl();
    bus.ID_PCSrc = 3'd5;
    #1;
    chk("ill_flush", {31'h0, bus.IF_flush}, 32'h1);
    tick();
    chk("ill_addr", bus.IM_addr, 32'h8000_0008);
    chk("ill_bubble", bus.ID_instruction, 32'h0);
    bus.ID_PCSrc = 3'd6;
    #1;
    chk("src6_flush", {31'h0, bus.IF_flush}, 32'h0);
    tick();
    chk("src6_addr", bus.IM_addr, 32'h8000_000C);
    chk("src6_instr", bus.ID_instruction, rom(32'h8000_0008));
    // Kernel-mode jr keeps the target's kernel bit.
    bus.ID_PCSrc = 3'd3;
    bus.ID_JrTarget = 32'h8000_0200;
    tick();
    chk("jr_kern_addr", bus.IM_addr, 32'h8000_0200);
    clear_ctrl();
  endtask

  task automatic test_mode_wrap();
    bus.ID_PCSrc = 3'd1;
    bus.IDcontrol_Branch = 1'b1;
    bus.ID_ConBA = 32'h7FFF_FFFC;
    tick();
    chk("uw_pre_addr", bus.IM_addr, 32'h7FFF_FFFC);
    clear_ctrl();
    tick();
    chk("uw_addr", bus.IM_addr, 32'h0000_0000);
    chk("uw_idpc", bus.ID_PC, 32'h0000_0000);
    chk("uw_instr", bus.ID_instruction, rom(32'h7FFF_FFFC));
    bus.ID_PCSrc = 3'd1;
    bus.IDcontrol_Branch = 1'b1;
    bus.ID_ConBA = 32'hFFFF_FFFC;
    tick();
    chk("kw_pre_addr", bus.IM_addr, 32'hFFFF_FFFC);
    clear_ctrl();
    tick();
    chk("kw_addr", bus.IM_addr, 32'h8000_0000);
    chk("kw_idpc", bus.ID_PC, 32'h8000_0000);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_ctrl();
    test_reset();
    test_branch();
    test_not_taken_stall();
    test_jumps();
    test_irq_stall();
    test_mode_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
